// File: rtl/conv_sequencer_if.sv
// Handshake and control bundle between the convolution sequencer and its
// weight/pixel sources and convolver datapath.
interface conv_sequencer_if;
    logic       start;
    logic       weight_valid;
    logic       weight_ready;
    logic       pixel_valid;
    logic       pixel_ready;
    logic [1:0] ctrl_state;
    logic       shift_en;
    logic       out_valid;
    logic       busy;
    logic       done;

    modport slave (
        input  start, weight_valid, pixel_valid,
        output weight_ready, pixel_ready, ctrl_state, shift_en, out_valid, busy, done
    );

    modport master (
        output start, weight_valid, pixel_valid,
        input  weight_ready, pixel_ready, ctrl_state, shift_en, out_valid, busy, done
    );
endinterface

// File: rtl/conv_sequencer.sv
// Sequences one convolution pass: loads KERNEL_SIZE^2 weights, streams one
// IMG_WIDTH x IMG_HEIGHT frame, then pulses done for one cycle.
module conv_sequencer #(
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 28,
    parameter int IMG_HEIGHT  = 28,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    conv_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_W = 2'd1,
        S_STREAM = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [1:0] CS_HOLD  = 2'b00;
    localparam logic [1:0] CS_WRITE = 2'b01;
    localparam logic [1:0] CS_SHIFT = 2'b10;

    localparam logic [CNT_W-1:0] LAST_WGT = CNT_W'(KERNEL_SIZE * KERNEL_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] WIN_MIN  = CNT_W'(KERNEL_SIZE - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_row;
    logic [1:0]       r_ctrl_state;
    logic             r_shift_en;
    logic             r_out_valid;

    logic w_w_acc;
    logic w_p_acc;

    assign w_w_acc = bus.weight_valid & (r_state == S_LOAD_W);
    assign w_p_acc = bus.pixel_valid  & (r_state == S_STREAM);

    assign bus.weight_ready = (r_state == S_LOAD_W);
    assign bus.pixel_ready  = (r_state == S_STREAM);
    assign bus.busy         = (r_state == S_LOAD_W) || (r_state == S_STREAM);
    assign bus.done         = (r_state == S_FINISH);
    assign bus.ctrl_state   = r_ctrl_state;
    assign bus.shift_en     = r_shift_en;
    assign bus.out_valid    = r_out_valid;

    // Per-beat outputs default to idle each cycle and are set only on an accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wcnt       <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_ctrl_state <= CS_HOLD;
            r_shift_en   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_ctrl_state <= CS_HOLD;
            r_shift_en   <= 1'b0;
            r_out_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_LOAD_W;
                        r_wcnt  <= '0;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                S_LOAD_W: begin
                    if (w_w_acc) begin
                        r_ctrl_state <= CS_WRITE;
                        r_wcnt       <= r_wcnt + 1'b1;
                        if (r_wcnt == LAST_WGT) begin
                            r_state <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (w_p_acc) begin
                        r_shift_en  <= 1'b1;
                        r_out_valid <= (r_row >= WIN_MIN) && (r_col >= WIN_MIN);
                        if (r_col == LAST_COL) begin
                            r_ctrl_state <= CS_SHIFT;
                            r_col        <= '0;
                            if (r_row == LAST_ROW) begin
                                r_state <= S_FINISH;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer with K=3, W=4, H=4: a vector table for one
// back-to-back pass plus sequences for gapped handshakes, mid-pass reset and stray starts.
module tb_conv_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_sequencer_if bus();

    conv_sequencer #(
        .KERNEL_SIZE(3),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (4),
        .CNT_W      (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst, st, wv, pv;
        logic       wr, pr;
        logic [1:0] cs;
        logic       se, ov, bz, dn;
    } vec_t;

    localparam int NV = 33;
    vec_t tbl[NV];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ctrl_state must never be 11 at any time.
    always @(negedge clk) begin
        total++;
        if (bus.ctrl_state === 2'b11) begin
            bad++;
            $display("FAIL ctrl_never_11: got 3 expected not 3");
        end
    end

    initial begin
        int nw, np, nwrap, nov, nd, guard;
        bit fin_pulsed, strm_pulsed;

        // Vector table: inputs for the cycle, outputs expected after its edge.
        for (int i = 0; i < NV; i++) begin
            tbl[i] = '{rst:0, st:0, wv:1, pv:1, wr:0, pr:0, cs:2'b00, se:0, ov:0, bz:0, dn:0};
        end
        tbl[0].rst = 1'b1;
        tbl[6].st = 1'b1; tbl[6].wr = 1'b1; tbl[6].bz = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tbl[7+i].cs = 2'b01;
            tbl[7+i].bz = 1'b1;
            tbl[7+i].wr = (i < 8);
            tbl[7+i].pr = (i == 8);
        end
        for (int p = 0; p < 16; p++) begin
            int r, c;
            r = p / 4;
            c = p % 4;
            tbl[16+p].se = 1'b1;
            tbl[16+p].cs = (c == 3) ? 2'b10 : 2'b00;
            tbl[16+p].ov = (r >= 2) && (c >= 2);
            tbl[16+p].pr = (p != 15);
            tbl[16+p].bz = (p != 15);
            tbl[16+p].dn = (p == 15);
        end
        tbl[32].wv = 1'b0; tbl[32].pv = 1'b0;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.weight_valid = 1'b0;
        bus.pixel_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            reset            = tbl[i].rst;
            bus.start        = tbl[i].st;
            bus.weight_valid = tbl[i].wv;
            bus.pixel_valid  = tbl[i].pv;
            step();
            chk($sformatf("v%0d.weight_ready", i), 8'(bus.weight_ready), 8'(tbl[i].wr));
            chk($sformatf("v%0d.pixel_ready", i),  8'(bus.pixel_ready),  8'(tbl[i].pr));
            chk($sformatf("v%0d.ctrl_state", i),   8'(bus.ctrl_state),   8'(tbl[i].cs));
            chk($sformatf("v%0d.shift_en", i),     8'(bus.shift_en),     8'(tbl[i].se));
            chk($sformatf("v%0d.out_valid", i),    8'(bus.out_valid),    8'(tbl[i].ov));
            chk($sformatf("v%0d.busy", i),         8'(bus.busy),         8'(tbl[i].bz));
            chk($sformatf("v%0d.done", i),         8'(bus.done),         8'(tbl[i].dn));
        end

        // Gapped valids, with start pulsed during STREAM and during FINISH.
        reset = 1'b1; bus.start = 1'b0; step();
        reset = 1'b0; bus.start = 1'b1; step();
        bus.start = 1'b0;
        nw = 0; np = 0; nwrap = 0; nov = 0; nd = 0;
        fin_pulsed = 1'b0; strm_pulsed = 1'b0;
        for (int c = 0; c < 150; c++) begin
            bus.weight_valid = (c % 3) != 2;
            bus.pixel_valid  = (c % 2) == 0;
            bus.start = 1'b0;
            if (bus.done && !fin_pulsed) begin
                bus.start = 1'b1;
                fin_pulsed = 1'b1;
            end else if (bus.pixel_ready && np == 5 && !strm_pulsed) begin
                bus.start = 1'b1;
                strm_pulsed = 1'b1;
            end
            step();
            if (bus.ctrl_state == 2'b01) nw++;
            if (bus.ctrl_state == 2'b10) nwrap++;
            if (bus.shift_en) np++;
            if (bus.out_valid) nov++;
            if (bus.done) nd++;
        end
        bus.start = 1'b0;
        chk("gap.weights", 8'(nw), 8'd9);
        chk("gap.shifts", 8'(np), 8'd16);
        chk("gap.wraps", 8'(nwrap), 8'd4);
        chk("gap.out_valid", 8'(nov), 8'd4);
        chk("gap.done", 8'(nd), 8'd1);
        chk("gap.busy_end", 8'(bus.busy), 8'd0);

        // Reset after the 7th pixel, then a fresh pass.
        bus.weight_valid = 1'b1; bus.pixel_valid = 1'b1;
        reset = 1'b1; step();
        reset = 1'b0; bus.start = 1'b1; step();
        bus.start = 1'b0;
        np = 0; guard = 0;
        while (np < 7 && guard < 40) begin
            step();
            if (bus.shift_en) np++;
            guard++;
        end
        chk("rst.reach_7th_pixel", 8'(np), 8'd7);
        reset = 1'b1; step();
        reset = 1'b0;
        chk("rst.busy", 8'(bus.busy), 8'd0);
        chk("rst.weight_ready", 8'(bus.weight_ready), 8'd0);
        chk("rst.pixel_ready", 8'(bus.pixel_ready), 8'd0);
        chk("rst.shift_en", 8'(bus.shift_en), 8'd0);
        chk("rst.ctrl_state", 8'(bus.ctrl_state), 8'd0);
        chk("rst.out_valid", 8'(bus.out_valid), 8'd0);
        chk("rst.done", 8'(bus.done), 8'd0);
        nd = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus.done || bus.busy) nd++;
        end
        chk("rst.idle_quiet", 8'(nd), 8'd0);

        bus.start = 1'b1; step();
        bus.start = 1'b0;
        nw = 0; guard = 0;
        while (!bus.pixel_ready && guard < 30) begin
            step();
            if (bus.ctrl_state == 2'b01) nw++;
            guard++;
        end
        chk("rst.reload_weights", 8'(nw), 8'd9);
        np = 0; nd = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.shift_en) np++;
            if (bus.done) nd++;
        end
        chk("rst.pass2_shifts", 8'(np), 8'd16);
        chk("rst.pass2_done", 8'(nd), 8'd1);
        chk("rst.pass2_busy_end", 8'(bus.busy), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
